seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 157 +++++++++++++++
 tb/tb_seq_detector_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime Moore/Mealy and overlap selection,
// saturating match counter and a 4-digit multiplexed hex display (digit 0 = state).
module seq_detector_param #(
  parameter int             N       = 6,
  parameter logic [N-1:0]   PATTERN = 6'b010110,
  parameter int             CNT_W   = 16,
  parameter int             REFRESH = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             X,
  input  logic             M,
  input  logic             OVL,
  output logic             Z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [6:0]       seg,
  output logic [3:0]       anode
);

  localparam int            RW       = $clog2(REFRESH);
  localparam logic [3:0]    N4       = 4'(N);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);

  logic [N-1:0]     hist_q, hist_d;
  logic [3:0]       vcnt_q, vcnt_d;
  logic             zq_q, zq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;

  logic [N-1:0]     win;
  logic             hit;
  logic [3:0]       sv;
  logic [N-1:0]     sv_mask;
  logic [11:0]      cnt12;
  logic [3:0]       digit_val;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign win = {hist_q[N-2:0], X};
  assign hit = (vcnt_q >= (N4 - 4'd1)) && (win == PATTERN);

  // Longest valid suffix of the history that is a prefix of the pattern.
  always_comb begin
    sv      = '0;
    sv_mask = '0;
    if (zq_q) begin
      sv = N4;
    end else begin
      for (int k = 1; k < N; k++) begin
        sv_mask = {N{1'b1}} >> (N - k);
        if ((4'(k) <= vcnt_q) &&
            ((hist_q & sv_mask) == ((PATTERN >> (N - k)) & sv_mask))) begin
          sv = 4'(k);
        end
      end
    end
  end

  always_comb begin
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    zq_d   = zq_q;
    cnt_d  = cnt_q;
    if (step) begin
      hist_d = win;
      vcnt_d = (vcnt_q == N4) ? N4 : vcnt_q + 4'd1;
      zq_d   = hit;
      if (hit) begin
        if (!OVL) begin
          vcnt_d = '0;
        end
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  generate
    if (CNT_W >= 12) begin : g_cnt_wide
      assign cnt12 = cnt_q[11:0];
    end else begin : g_cnt_narrow
      assign cnt12 = {{(12 - CNT_W){1'b0}}, cnt_q};
    end
  endgenerate

  // seg and anode are computed for the upcoming digit so both flip in the same cycle.
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end
    case (digit_d)
      2'd0:    digit_val = sv;
      2'd1:    digit_val = cnt12[3:0];
      2'd2:    digit_val = cnt12[7:4];
      default: digit_val = cnt12[11:8];
    endcase
    anode_d = ~(4'b0001 << digit_d);
    seg_d   = hex7(digit_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= '0;
      vcnt_q    <= '0;
      zq_q      <= 1'b0;
      cnt_q     <= '0;
      refresh_q <= '0;
      digit_q   <= 2'd0;
      anode_q   <= 4'b1110;
      seg_q     <= 7'b0000001;
    end else begin
      hist_q    <= hist_d;
      vcnt_q    <= vcnt_d;
      zq_q      <= zq_d;
      cnt_q     <= cnt_d;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign Z         = M ? hit : zq_q;
  assign match_cnt = cnt_q;
  assign seg       = seg_q;
  assign anode     = anode_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized stepping, checked
// against a bit-queue reference model; a second instance with CNT_W=4 covers saturation.
module tb_seq_detector_param;

  localparam int           N    = 6;
  localparam logic [N-1:0] PAT  = 6'b010110;
  localparam int           REFR = 4;

  logic        clk = 1'b0;
  logic        reset, step, X, M, OVL;
  logic        z, z4;
  logic [15:0] mc16;
  logic [3:0]  mc4;
  logic [6:0]  seg16, seg4;
  logic [3:0]  an16, an4;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit q[$];
  bit mzq;
  int mcnt16, mcnt4;
  int pidx = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seq_detector_param #(.N(N), .PATTERN(PAT), .CNT_W(16), .REFRESH(REFR)) dut (
    .clk(clk), .reset(reset), .step(step), .X(X), .M(M), .OVL(OVL),
    .Z(z), .match_cnt(mc16), .seg(seg16), .anode(an16));

  seq_detector_param #(.N(N), .PATTERN(PAT), .CNT_W(4), .REFRESH(REFR)) dut4 (
    .clk(clk), .reset(reset), .step(step), .X(X), .M(M), .OVL(OVL),
    .Z(z4), .match_cnt(mc4), .seg(seg4), .anode(an4));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Match if the last N-1 accepted bits followed by x spell the pattern.
  function automatic bit model_hit(input bit x);
    int sz = q.size();
    if (sz < N - 1) return 1'b0;
    for (int i = 0; i < N - 1; i++)
      if (q[sz - (N - 1) + i] != PAT[N - 1 - i]) return 1'b0;
    return x == PAT[0];
  endfunction

  function automatic int model_sv();
    int best = 0;
    int sz = q.size();
    bit ok;
    if (mzq) return N;
    for (int k = 1; k < N; k++) begin
      if (k <= sz) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (q[sz - k + j] != PAT[N - 1 - j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic void model_apply(input bit x, input bit ovl);
    bit h = model_hit(x);
    mzq = h;
    if (h) begin
      if (mcnt16 < 65535) mcnt16++;
      if (mcnt4 < 15) mcnt4++;
    end
    if (h && !ovl) begin
      q.delete();
    end else begin
      q.push_back(x);
      if (q.size() > N) void'(q.pop_front());
    end
  endfunction

  function automatic void model_clear();
    q.delete();
    mzq = 1'b0;
    mcnt16 = 0;
    mcnt4 = 0;
  endfunction

  function automatic int dval(input int idx, input int cnt);
    if (idx == 0) return model_sv();
    return (cnt >> (4 * (idx - 1))) & 15;
  endfunction

  task automatic check_all();
    int idx = (cyc / REFR) % 4;
    logic [3:0] ea = 4'b1111 ^ (4'b0001 << idx);
    bit ez = M ? model_hit(X) : mzq;
    chk("z", z, ez);
    chk("z4", z4, ez);
    chk("cnt16", mc16, mcnt16);
    chk("cnt4", mc4, mcnt4);
    chk("anode", an16, ea);
    chk("anode4", an4, ea);
    chk("seg", seg16, seg_tab[dval(idx, mcnt16)]);
    chk("seg4", seg4, seg_tab[dval(idx, mcnt4)]);
  endtask

  task automatic do_reset(input bit with_step);
    @(negedge clk);
    reset = 1'b1;
    step  = with_step;
    @(negedge clk);
    reset = 1'b0;
    step  = 1'b0;
    model_clear();
    pidx = 0;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_burst(input bit x, input int n);
    @(negedge clk);
    X = x;
    step = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_apply(x, OVL);
      @(negedge clk);
    end
    step = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_step(input bit x);
    do_burst(x, 1);
  endtask

  task automatic send_pattern();
    for (int i = N - 1; i >= 0; i--) do_step(PAT[i]);
  endtask

  initial begin
    bit s0 [6]  = '{0, 1, 0, 1, 1, 0};
    bit s1 [11] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
    logic [6:0] disp_exp [4] = '{7'b0000001, 7'b0000110, 7'b0010010, 7'b1001111};
    int idx, budget;
    bit b;

    reset = 1'b1; step = 1'b0; X = 1'b0; M = 1'b0; OVL = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset(1'b0);
    chk("rst_anode", an16, 4'b1110);
    chk("rst_seg", seg16, 7'b0000001);

    // Moore, overlapping
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("moore_pre", z, 1'b0);
      do_step(s0[i]);
    end
    chk("moore_hit", z, 1'b1);
    chk("moore_cnt", mc16, 1);
    do_step(1'b1);
    chk("moore_drop", z, 1'b0);

    // Mealy: Z rises before the completing step
    do_reset(1'b0);
    M = 1'b1;
    for (int i = 0; i < 5; i++) do_step(s0[i]);
    @(negedge clk);
    X = 1'b0; #1;
    chk("mealy_early", z, 1'b1);
    X = 1'b1; #1;
    chk("mealy_xdrop", z, 1'b0);
    do_step(1'b0);
    chk("mealy_cnt", mc16, 1);
    M = 1'b0;

    // Overlap vs non-overlap
    do_reset(1'b0);
    OVL = 1'b1;
    foreach (s1[i]) do_step(s1[i]);
    chk("ovl_cnt", mc16, 2);
    do_reset(1'b0);
    OVL = 1'b0;
    foreach (s1[i]) do_step(s1[i]);
    chk("novl_cnt", mc16, 1);

    // Reset mid-pattern discards the partial match
    do_reset(1'b0);
    OVL = 1'b1;
    for (int i = 0; i < 4; i++) do_step(s0[i]);
    do_reset(1'b1);
    do_step(1'b1); do_step(1'b1); do_step(1'b0);
    chk("midrst_z", z, 1'b0);
    chk("midrst_cnt", mc16, 0);

    // Saturation of the narrow counter
    do_reset(1'b0);
    OVL = 1'b0;
    repeat (20) send_pattern();
    chk("sat_cnt4", mc4, 4'hF);
    chk("sat_cnt16", mc16, 20);
    budget = 0;
    while (((cyc / REFR) % 4) != 1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("sat_budget", budget < 20, 1'b1);
    chk("sat_digit1", seg4, 7'b0111000);

    // Display scan with count 0x123 and state 0
    do_reset(1'b0);
    OVL = 1'b0;
    repeat (291) send_pattern();
    do_step(1'b1);
    chk("disp_cnt", mc16, 16'h0123);
    for (int i = 0; i < 4 * REFR + 4; i++) begin
      @(negedge clk);
      idx = (cyc / REFR) % 4;
      chk("disp_anode", an16, 4'b1111 ^ (4'b0001 << idx));
      chk("disp_seg", seg16, disp_exp[idx]);
    end

    // Randomized phase
    do_reset(1'b0);
    for (int it = 0; it < 700; it++) begin
      int r = $urandom_range(0, 99);
      b = ($urandom_range(0, 7) == 0) ? 1'($urandom) : PAT[N - 1 - pidx];
      pidx = (pidx + 1) % N;
      if (r < 3) begin
        do_reset(1'($urandom));
      end else if (r < 10) begin
        M = ~M;
      end else if (r < 15) begin
        OVL = ~OVL;
      end else if (r < 25) begin
        do_burst(b, $urandom_range(2, 3));
      end else if (r < 35) begin
        @(negedge clk);
        X = 1'($urandom); #1;
        check_all();
      end else begin
        do_step(b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
